// File: rtl/traffic_pkg.sv
// Shared constants for the intersection light controller and its upstream
// request arbiter: controller state codes, light encodings and the arbiter mode.
package traffic_pkg;

   localparam logic [3:0] CODE_ALL_RED = 4'd6;
   localparam logic [3:0] CODE_EMG     = 4'd7;
   localparam logic [3:0] CODE_CAU     = 4'd8;

   localparam logic [2:0] LIGHT_GREEN  = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b001;
   localparam logic [2:0] LIGHT_OFF    = 3'b000;

   typedef enum logic [1:0] {
      MODE_INIT = 2'd0,
      MODE_RUN  = 2'd1,
      MODE_EMG  = 2'd2,
      MODE_CAU  = 2'd3
   } mode_e;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// only follows the synchronised input after DEBOUNCE_CYC steady cycles.
module input_debouncer #(
   parameter int DEBOUNCE_CYC = 16,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic db_o
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             prev_q;
   logic             db_q;
   logic             db_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // prev_q lets any change of the synchronised value restart the count
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q && sync2_q == prev_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_d == DB_LAST) begin
            db_d = ~db_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/traffic_request_arbiter.sv
// Debounces emergency/caution requests and issues one-cycle load pulses with a
// held state code to the light controller; emergency outranks caution.
module traffic_request_arbiter
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int MIN_HOLD_CYC = 1000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       emg_raw,
   input  logic       cau_raw,
   output logic       en,
   output logic       ld,
   output logic [3:0] data,
   output logic [1:0] mode
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD_CYC);

   logic             emg_db;
   logic             cau_db;
   mode_e            state_q;
   logic             ld_q;
   logic             en_q;
   logic [3:0]       data_q;
   logic [CNT_W-1:0] hold_q;
   logic             hold_done;

   input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_emg_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (emg_raw),
      .db_o  (emg_db)
   );

   input_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_cau_db (
      .clk   (clk),
      .rst   (rst),
      .raw_i (cau_raw),
      .db_o  (cau_db)
   );

   assign hold_done = (hold_q == HOLD_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MODE_INIT;
         ld_q    <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= CODE_ALL_RED;
         hold_q  <= '0;
      end else begin
         ld_q <= 1'b0;
         en_q <= 1'b1;
         if (!hold_done) begin
            hold_q <= hold_q + CNT_W'(1);
         end
         case (state_q)
            // en_q is still low only on the first cycle out of reset
            MODE_INIT: begin
               if (!en_q) begin
                  ld_q   <= 1'b1;
                  data_q <= CODE_ALL_RED;
               end else begin
                  state_q <= MODE_RUN;
                  hold_q  <= '0;
               end
            end
            MODE_RUN: begin
               if (emg_db) begin
                  state_q <= MODE_EMG;
                  ld_q    <= 1'b1;
                  data_q  <= CODE_EMG;
                  hold_q  <= '0;
               end else if (cau_db) begin
                  state_q <= MODE_CAU;
                  ld_q    <= 1'b1;
                  data_q  <= CODE_CAU;
                  hold_q  <= '0;
               end
            end
            MODE_EMG: begin
               if (!emg_db && hold_done) begin
                  ld_q   <= 1'b1;
                  hold_q <= '0;
                  if (cau_db) begin
                     state_q <= MODE_CAU;
                     data_q  <= CODE_CAU;
                  end else begin
                     state_q <= MODE_RUN;
                     data_q  <= CODE_ALL_RED;
                  end
               end
            end
            // Pre-emption waits one cycle if CAU was entered on the previous edge
            MODE_CAU: begin
               if (emg_db && !ld_q) begin
                  state_q <= MODE_EMG;
                  ld_q    <= 1'b1;
                  data_q  <= CODE_EMG;
                  hold_q  <= '0;
               end else if (!cau_db && hold_done) begin
                  state_q <= MODE_RUN;
                  ld_q    <= 1'b1;
                  data_q  <= CODE_ALL_RED;
                  hold_q  <= '0;
               end
            end
            default: begin
               state_q <= MODE_INIT;
            end
         endcase
      end
   end

   assign en   = en_q;
   assign ld   = ld_q;
   assign data = data_q;
   assign mode = state_q;

endmodule
